banco_registradores_param: RTL and testbench
============================================

Name: banco_registradores_param

Overview:
Parametrised register bank: 2^N_END registers of LARGURA bits, one write port, two registered read ports. The write-address decoder is built in and registered, and its one-hot select is exported for debug and bench visibility. A sequential clear engine zeroes the bank one register per cycle. The block sits in the datapath between instruction decode (addresses) and the ALU (operands and results).

Parameters:
LARGURA, 16, data width of each register and of the data ports
N_END, 3, address width; depth = 2^N_END registers
ZERO_FIXO, 0, when 1: register 0 always reads 0 and writes to it are discarded

Ports:
clock  input  1  single clock, rising edge
resetn  input  1  asynchronous, active-low reset
escrita  input  1  write enable, sampled on the rising edge
end_escrita  input  N_END  write address
dado_escrita  input  LARGURA  write data
end_leitura_a  input  N_END  read port A address
end_leitura_b  input  N_END  read port B address
limpar  input  1  clear request, sampled on the rising edge
leitura_a  output  LARGURA  registered read data, port A
leitura_b  output  LARGURA  registered read data, port B
sel_escrita  output  2^N_END  registered one-hot select of the last accepted write
ocupado  output  1  high while the clear engine is running

Behaviour:
- Interface: one clock (clock). Reset (resetn) is asynchronous and active-low.
- Reset (resetn=0), immediate, no clock needed:
  - all registers = 0; leitura_a = leitura_b = 0; sel_escrita = 0; ocupado = 0
  - state = OCIOSO; clear counter = 0
  - reset asserted mid-clear aborts the sweep; the bank is zero anyway.
- States: OCIOSO, LIMPANDO.
- Accepted write: escrita=1, state OCIOSO, limpar=0 at the edge.
  - reg[end_escrita] <= dado_escrita
  - exception: ZERO_FIXO=1 and end_escrita=0 — the data is discarded, but the write still counts as accepted for sel_escrita.
- sel_escrita, updated every edge:
  - after an accepted write: exactly bit end_escrita = 1
  - otherwise: all zeros
  - so it is a one-cycle pulse per accepted write, and never holds more than one hot bit.
- Reads: 1-cycle latency; both ports independent and evaluated every edge, including during LIMPANDO.
  - leitura_x <= reg[end_leitura_x] (pre-edge contents)
  - write-first bypass: if a write is accepted at the same edge and end_escrita = end_leitura_x, then leitura_x <= dado_escrita.
  - ZERO_FIXO=1 and end_leitura_x=0: leitura_x <= 0, with no bypass.
  - A=B address is legal; both ports return identical data.
- Clear engine:
  - OCIOSO + limpar=1 at an edge: go to LIMPANDO, counter <= 0, ocupado <= 1. A simultaneous escrita is dropped (clear has priority).
  - Each edge in LIMPANDO: reg[counter] <= 0, counter <= counter+1.
  - At the edge that clears reg[2^N_END-1]: go to OCIOSO, ocupado <= 0, counter <= 0 (wrap).
  - ocupado is high for exactly 2^N_END cycles.
  - escrita during LIMPANDO is ignored: no register change, sel_escrita = 0.
  - limpar during LIMPANDO is ignored; the sweep is not restarted.
  - A read of a register during LIMPANDO returns its pre-edge value, so a register cleared at that same edge still shows its old value.
- No combinational path from any input to any output.

Test Plan:
- Reset value check (N_END=3, LARGURA=16): pulse resetn low with clock stopped -> all outputs 0 immediately; every register then reads 0 on both ports.
- Write/read: write 0xA5A5 to addr 5, then read A=5, B=5 on the next cycle -> sel_escrita=0b0010_0000 for one cycle, then both ports = 0xA5A5 one cycle after the read addresses are presented.
- Bypass: escrita=1, end_escrita=3, dado=0x1234, end_leitura_a=3, with reg[3]=0x0001 beforehand -> leitura_a=0x1234 after that same edge; leitura_b on addr 4 is unaffected.
- ZERO_FIXO=1: write 0xFFFF to addr 0 -> sel_escrita bit0 pulses; leitura_a at addr 0 = 0x0000, including the bypass case.
- Clear: fill regs 0..7 with 0x0011..0x0088, then pulse limpar with escrita=1 to addr 2 in the same cycle -> addr-2 write dropped; ocupado high exactly 8 cycles; writes during the sweep ignored; all regs read 0 afterwards; a write the cycle after ocupado falls is accepted.
- Reset mid-clear: assert resetn=0 at sweep counter=4 -> ocupado=0 and all regs 0 immediately; after release the state is OCIOSO and the first write is accepted.

Source files
------------

// File: rtl/banco_registradores_param.sv
// -----------------------------------------------------------------------------
// banco_registradores_param
//
// Purpose: parametrised register bank sitting between instruction decode and
// the ALU. It holds 2^N_END registers of LARGURA bits and has one write port
// and two independent registered read ports. The registered one-hot write
// select is exported for debug, and a clear engine zeroes the bank one
// register per cycle.
//
// Parameters:
//   LARGURA   data width of each register and of the data ports
//   N_END     address width (depth = 2^N_END)
//   ZERO_FIXO when 1, register 0 always reads 0 and writes to it are discarded
//
// Ports:
//   clock          in   rising-edge clock
//   resetn         in   asynchronous active-low reset
//   escrita        in   write enable
//   end_escrita    in   write address
//   dado_escrita   in   write data
//   end_leitura_a  in   read address, port A
//   end_leitura_b  in   read address, port B
//   limpar         in   clear request
//   leitura_a      out  registered read data, port A (1-cycle latency)
//   leitura_b      out  registered read data, port B (1-cycle latency)
//   sel_escrita    out  one-cycle one-hot pulse of the last accepted write
//   ocupado        out  high while the clear engine is sweeping
// -----------------------------------------------------------------------------
module banco_registradores_param #(
  parameter int LARGURA   = 16,
  parameter int N_END     = 3,
  parameter int ZERO_FIXO = 0
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    escrita,
  input  logic [N_END-1:0]        end_escrita,
  input  logic [LARGURA-1:0]      dado_escrita,
  input  logic [N_END-1:0]        end_leitura_a,
  input  logic [N_END-1:0]        end_leitura_b,
  input  logic                    limpar,
  output logic [LARGURA-1:0]      leitura_a,
  output logic [LARGURA-1:0]      leitura_b,
  output logic [(2**N_END)-1:0]   sel_escrita,
  output logic                    ocupado
);

  localparam int PROF = 2 ** N_END;

  typedef enum logic [0:0] {
    OCIOSO   = 1'b0,
    LIMPANDO = 1'b1
  } estado_t;

  estado_t                state_q,     state_d;
  logic [N_END-1:0]       cnt_q,       cnt_d;
  logic [LARGURA-1:0]     mem_q [PROF];
  logic [LARGURA-1:0]     mem_d [PROF];
  logic [LARGURA-1:0]     leitura_a_q, leitura_a_d;
  logic [LARGURA-1:0]     leitura_b_q, leitura_b_d;
  logic [PROF-1:0]        sel_q,       sel_d;
  logic                   ocupado_q,   ocupado_d;
  logic                   wr_ok_s;

  // Read-port value: register 0 is hard-wired to zero when ZERO_FIXO is set
  // (that case wins over the bypass); otherwise a write accepted at the same
  // edge to the same address is forwarded (write-first).
  function automatic logic [LARGURA-1:0] ler(
    input logic [N_END-1:0]   addr,
    input logic               wr_ok,
    input logic [N_END-1:0]   end_w,
    input logic [LARGURA-1:0] dado,
    input logic [LARGURA-1:0] mem_val
  );
    logic [LARGURA-1:0] val;
    if ((ZERO_FIXO != 0) && (addr == {N_END{1'b0}})) begin
      val = {LARGURA{1'b0}};
    end else if (wr_ok && (end_w == addr)) begin
      val = dado;
    end else begin
      val = mem_val;
    end
    return val;
  endfunction

  // Next-state logic: clear engine FSM, bank update, write select and reads.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ocupado_d = ocupado_q;
    mem_d     = mem_q;
    sel_d     = {PROF{1'b0}};
    wr_ok_s   = 1'b0;

    case (state_q)
      OCIOSO: begin
        if (limpar) begin
          // Clear has priority; a simultaneous write is dropped.
          state_d   = LIMPANDO;
          cnt_d     = {N_END{1'b0}};
          ocupado_d = 1'b1;
        end else if (escrita) begin
          wr_ok_s            = 1'b1;
          sel_d[end_escrita] = 1'b1;
          // The write still counts as accepted even when the data is
          // discarded for a hard-wired zero register.
          if ((ZERO_FIXO != 0) && (end_escrita == {N_END{1'b0}})) begin
            mem_d = mem_q;
          end else begin
            mem_d[end_escrita] = dado_escrita;
          end
        end else begin
          state_d = OCIOSO;
        end
      end
      LIMPANDO: begin
        mem_d[cnt_q] = {LARGURA{1'b0}};
        if (&cnt_q) begin
          state_d   = OCIOSO;
          cnt_d     = {N_END{1'b0}};
          ocupado_d = 1'b0;
        end else begin
          cnt_d = cnt_q + N_END'(1'b1);
        end
      end
      default: begin
        state_d   = OCIOSO;
        cnt_d     = {N_END{1'b0}};
        ocupado_d = 1'b0;
      end
    endcase

    // Reads use pre-edge contents, so a register being cleared this edge
    // still shows its old value.
    leitura_a_d = ler(end_leitura_a, wr_ok_s, end_escrita, dado_escrita,
                      mem_q[end_leitura_a]);
    leitura_b_d = ler(end_leitura_b, wr_ok_s, end_escrita, dado_escrita,
                      mem_q[end_leitura_b]);
  end

  // State, bank and output registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= OCIOSO;
      cnt_q       <= {N_END{1'b0}};
      ocupado_q   <= 1'b0;
      sel_q       <= {PROF{1'b0}};
      leitura_a_q <= {LARGURA{1'b0}};
      leitura_b_q <= {LARGURA{1'b0}};
      for (int i = 0; i < PROF; i++) begin
        mem_q[i] <= {LARGURA{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ocupado_q   <= ocupado_d;
      sel_q       <= sel_d;
      leitura_a_q <= leitura_a_d;
      leitura_b_q <= leitura_b_d;
      for (int i = 0; i < PROF; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign leitura_a   = leitura_a_q;
  assign leitura_b   = leitura_b_q;
  assign sel_escrita = sel_q;
  assign ocupado     = ocupado_q;

endmodule

// File: tb/tb_banco_registradores_param.sv
// -----------------------------------------------------------------------------
// Bench for banco_registradores_param. Two instances share all inputs: one
// with ZERO_FIXO=0 (dut0) and one with ZERO_FIXO=1 (dut1). A behavioural model
// holds the bank contents as plain arrays plus a "sweep in progress" flag.
// -----------------------------------------------------------------------------
module tb_banco_registradores_param;

  logic        clock = 1'b0;
  logic        resetn;
  logic        escrita;
  logic [2:0]  end_escrita;
  logic [15:0] dado_escrita;
  logic [2:0]  end_leitura_a;
  logic [2:0]  end_leitura_b;
  logic        limpar;

  logic [15:0] la0, lb0, la1, lb1;
  logic [7:0]  sel0, sel1;
  logic        ocup0, ocup1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m0 [8];
  logic [15:0] m1 [8];
  logic        m_limp;
  int          m_idx;

  always #5 clock = ~clock;

  banco_registradores_param #(.LARGURA(16), .N_END(3), .ZERO_FIXO(0)) dut0 (
    .clock(clock), .resetn(resetn), .escrita(escrita),
    .end_escrita(end_escrita), .dado_escrita(dado_escrita),
    .end_leitura_a(end_leitura_a), .end_leitura_b(end_leitura_b),
    .limpar(limpar), .leitura_a(la0), .leitura_b(lb0),
    .sel_escrita(sel0), .ocupado(ocup0)
  );

  banco_registradores_param #(.LARGURA(16), .N_END(3), .ZERO_FIXO(1)) dut1 (
    .clock(clock), .resetn(resetn), .escrita(escrita),
    .end_escrita(end_escrita), .dado_escrita(dado_escrita),
    .end_leitura_a(end_leitura_a), .end_leitura_b(end_leitura_b),
    .limpar(limpar), .leitura_a(la1), .leitura_b(lb1),
    .sel_escrita(sel1), .ocupado(ocup1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m0[i] = 16'h0000;
      m1[i] = 16'h0000;
    end
    m_limp = 1'b0;
    m_idx  = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_la0"}, {16'h0, la0}, 32'h0);
    chk({tag, "_lb0"}, {16'h0, lb0}, 32'h0);
    chk({tag, "_sel0"}, {24'h0, sel0}, 32'h0);
    chk({tag, "_ocup0"}, {31'h0, ocup0}, 32'h0);
    chk({tag, "_la1"}, {16'h0, la1}, 32'h0);
    chk({tag, "_lb1"}, {16'h0, lb1}, 32'h0);
    chk({tag, "_sel1"}, {24'h0, sel1}, 32'h0);
    chk({tag, "_ocup1"}, {31'h0, ocup1}, 32'h0);
  endtask

  // Expected read: what the register holds now, or the data being written
  // this cycle to the same address; a hard-wired zero register reads 0.
  function automatic logic [15:0] exp_rd(input logic zf, input logic acc,
                                         input logic [2:0] ew, input logic [15:0] d,
                                         input logic [2:0] ra, input logic [15:0] cur);
    if (zf && ra == 3'd0) return 16'h0000;
    if (acc && ew == ra) return d;
    return cur;
  endfunction

  // One clock cycle: drive inputs, predict, advance the model, clock, compare.
  task automatic ciclo(input string tag, input logic esc, input logic [2:0] ew,
                       input logic [15:0] d, input logic [2:0] ra,
                       input logic [2:0] rb, input logic lim);
    logic        acc;
    logic [15:0] ea0, eb0, ea1, eb1;
    logic [7:0]  es;
    escrita = esc; end_escrita = ew; dado_escrita = d;
    end_leitura_a = ra; end_leitura_b = rb; limpar = lim;
    acc = esc && !m_limp && !lim;
    ea0 = exp_rd(1'b0, acc, ew, d, ra, m0[ra]);
    eb0 = exp_rd(1'b0, acc, ew, d, rb, m0[rb]);
    ea1 = exp_rd(1'b1, acc, ew, d, ra, m1[ra]);
    eb1 = exp_rd(1'b1, acc, ew, d, rb, m1[rb]);
    es  = acc ? (8'h01 << ew) : 8'h00;
    if (m_limp) begin
      m0[m_idx] = 16'h0000;
      m1[m_idx] = 16'h0000;
      if (m_idx == 7) begin
        m_limp = 1'b0;
        m_idx  = 0;
      end else begin
        m_idx++;
      end
    end else if (lim) begin
      m_limp = 1'b1;
      m_idx  = 0;
    end else if (acc) begin
      m0[ew] = d;
      if (ew != 3'd0) m1[ew] = d;
    end
    @(posedge clock);
    #1;
    chk({tag, "_la0"}, {16'h0, la0}, {16'h0, ea0});
    chk({tag, "_lb0"}, {16'h0, lb0}, {16'h0, eb0});
    chk({tag, "_la1"}, {16'h0, la1}, {16'h0, ea1});
    chk({tag, "_lb1"}, {16'h0, lb1}, {16'h0, eb1});
    chk({tag, "_sel0"}, {24'h0, sel0}, {24'h0, es});
    chk({tag, "_sel1"}, {24'h0, sel1}, {24'h0, es});
    chk({tag, "_ocup0"}, {31'h0, ocup0}, {31'h0, m_limp});
    chk({tag, "_ocup1"}, {31'h0, ocup1}, {31'h0, m_limp});
  endtask

  initial begin
    int busy_cycles;
    model_reset();
    escrita = 1'b0; end_escrita = 3'd0; dado_escrita = 16'h0;
    end_leitura_a = 3'd0; end_leitura_b = 3'd0; limpar = 1'b0;

    // Reset asserted before any clock edge: outputs must be zero immediately.
    resetn = 1'b0;
    #2;
    chk_all_zero("reset");
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // Every register reads 0 on both ports after reset.
    for (int i = 0; i < 8; i++) ciclo("rd_reset", 1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 1'b0);

    // Write then read: sel pulse on bit 5, both ports return the data.
    ciclo("wr5", 1'b1, 3'd5, 16'hA5A5, 3'd0, 3'd1, 1'b0);
    ciclo("rd5", 1'b0, 3'd0, 16'h0, 3'd5, 3'd5, 1'b0);
    chk("rd5_direct", {16'h0, la0}, 32'h0000A5A5);

    // Bypass: reg3 holds 0x0001, same-edge write of 0x1234 is forwarded.
    ciclo("wr3", 1'b1, 3'd3, 16'h0001, 3'd0, 3'd0, 1'b0);
    ciclo("byp3", 1'b1, 3'd3, 16'h1234, 3'd3, 3'd4, 1'b0);
    chk("byp3_direct", {16'h0, la0}, 32'h00001234);

    // Register 0 write: discarded only in the ZERO_FIXO instance.
    ciclo("wr0_byp", 1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 1'b0);
    chk("zf_byp_direct", {16'h0, la1}, 32'h0);
    ciclo("rd0", 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0);

    // Clear: fill, request clear with a simultaneous write, count ocupado.
    for (int i = 0; i < 8; i++) ciclo("fill", 1'b1, 3'(i), 16'(16'h0011 * (i + 1)), 3'(i), 3'd2, 1'b0);
    ciclo("clr_start", 1'b1, 3'd2, 16'hBEEF, 3'd2, 3'd5, 1'b1);
    busy_cycles = ocup0 ? 1 : 0;
    for (int k = 0; k < 12 && ocup0; k++) begin
      ciclo("sweep", 1'b1, 3'($urandom_range(0, 7)), 16'($urandom), 3'(k % 8), 3'(7 - (k % 8)), 1'b0);
      if (ocup0) busy_cycles++;
    end
    chk("ocupado_len", busy_cycles, 32'd8);
    ciclo("wr_after_clr", 1'b1, 3'd6, 16'h7777, 3'd6, 3'd2, 1'b0);
    chk("wr_after_clr_sel", {24'h0, sel0}, 32'h40);
    for (int i = 0; i < 8; i++) ciclo("rd_clr", 1'b0, 3'd0, 16'h0, 3'(i), 3'(i), 1'b0);

    // Reset in the middle of a sweep (counter = 4).
    for (int i = 0; i < 8; i++) ciclo("fill2", 1'b1, 3'(i), 16'(16'h1000 + i), 3'(i), 3'd0, 1'b0);
    ciclo("clr2_start", 1'b0, 3'd0, 16'h0, 3'd7, 3'd6, 1'b1);
    for (int i = 0; i < 4; i++) ciclo("sweep2", 1'b0, 3'd0, 16'h0, 3'd7, 3'd6, 1'b0);
    resetn = 1'b0;
    #1;
    model_reset();
    chk_all_zero("midreset");
    #1;
    resetn = 1'b1;
    ciclo("wr_after_rst", 1'b1, 3'd1, 16'h4242, 3'd1, 3'd7, 1'b0);
    chk("wr_after_rst_sel", {24'h0, sel0}, 32'h02);
    for (int i = 0; i < 8; i++) ciclo("rd_rst", 1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 1'b0);

    // Random traffic with occasional clears.
    for (int n = 0; n < 400; n++) begin
      ciclo("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 24) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
